// File: rtl/al_set_control.sv
`default_nettype none
// ============================================================================
// Module   : al_set_control
// Purpose  : Alarm-set front end: button synchronise/debounce, field-select
//            FSM, commit/abort pulses. Define AL_TIMEOUT_EN for idle auto-exit.
// Revision : 1.0 - initial release
// ============================================================================
module al_set_control #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_SET_RAW,
    input  logic       BTN_INC_RAW,
    input  logic       BTN_DEC_RAW,
    output logic       BTN_SET,
    output logic       BTN_INC,
    output logic       BTN_DEC,
    output logic       prev_SET,
    output logic       setFlag,
    output logic       targetFlag_H,
    output logic       targetFlag_M,
    output logic       targetFlag_S,
    output logic [1:0] field,
    output logic       commit,
    output logic       abort
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    logic [2:0] raw;
    logic [2:0] db;

    assign raw = {BTN_DEC_RAW, BTN_INC_RAW, BTN_SET_RAW};

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic             s1;
        logic             s2;
        logic             out;
        logic [CNT_W-1:0] cnt;

        // Any return of s2 to the current output level restarts the count.
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                out <= 1'b0;
                cnt <= '0;
            end else begin
                s1 <= raw[i];
                s2 <= s1;
                if (s2 == out) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    out <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign db[i] = out;
    end

    assign BTN_SET = db[0];
    assign BTN_INC = db[1];
    assign BTN_DEC = db[2];

    state_t state;
    state_t next_state;
    logic   set_rise;
    logic   timeout;
    logic   exit_commit;
    logic   exit_abort;

    assign set_rise = BTN_SET & ~prev_SET;

`ifdef AL_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] timer;
    logic             any_btn;

    assign any_btn = BTN_SET | BTN_INC | BTN_DEC;
    assign timeout = (state != IDLE) && !any_btn && (timer == TMR_LAST);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            timer <= '0;
        end else if ((state == IDLE) || any_btn || timeout) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end
`else
    // Timer not built; expression is constant false for any legal parameter.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        next_state  = state;
        exit_commit = 1'b0;
        exit_abort  = 1'b0;
        if (set_rise) begin
            case (state)
                IDLE:  next_state = SET_H;
                SET_H: next_state = SET_M;
                SET_M: next_state = SET_S;
                SET_S: begin
                    next_state  = IDLE;
                    exit_commit = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end else if (timeout) begin
            next_state = IDLE;
            exit_abort = 1'b1;
        end
    end

    // Outputs are decoded from next_state so they appear on the same edge as the state.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= IDLE;
            prev_SET     <= 1'b0;
            setFlag      <= 1'b0;
            targetFlag_H <= 1'b0;
            targetFlag_M <= 1'b0;
            targetFlag_S <= 1'b0;
            field        <= 2'd0;
            commit       <= 1'b0;
            abort        <= 1'b0;
        end else begin
            state        <= next_state;
            prev_SET     <= BTN_SET;
            setFlag      <= (next_state != IDLE);
            targetFlag_H <= (next_state == SET_H);
            targetFlag_M <= (next_state == SET_M);
            targetFlag_S <= (next_state == SET_S);
            field        <= next_state;
            commit       <= exit_commit;
            abort        <= exit_abort;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_al_set_control.sv
`default_nettype none
// Scoreboard bench for al_set_control: stimulus queues expected output changes,
// a negedge monitor pops one entry per observed output change.
module tb_al_set_control;

    localparam int DB = 4;
    localparam int TO = 20;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       set_raw = 1'b0;
    logic       inc_raw = 1'b0;
    logic       dec_raw = 1'b0;
    logic       BTN_SET, BTN_INC, BTN_DEC, prev_SET, setFlag;
    logic       targetFlag_H, targetFlag_M, targetFlag_S, commit, abort;
    logic [1:0] field;

    al_set_control #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .BTN_SET_RAW  (set_raw),
        .BTN_INC_RAW  (inc_raw),
        .BTN_DEC_RAW  (dec_raw),
        .BTN_SET      (BTN_SET),
        .BTN_INC      (BTN_INC),
        .BTN_DEC      (BTN_DEC),
        .prev_SET     (prev_SET),
        .setFlag      (setFlag),
        .targetFlag_H (targetFlag_H),
        .targetFlag_M (targetFlag_M),
        .targetFlag_S (targetFlag_S),
        .field        (field),
        .commit       (commit),
        .abort        (abort)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [11:0] v;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic       e_bset = 0, e_binc = 0, e_bdec = 0, e_prev = 0, e_commit = 0, e_abort = 0;
    logic [1:0] e_field = 2'd0;
    bit         mon_en = 0;
    logic [11:0] last_obs = 12'd0;
    bit         rise_win = 0;
    int         rise_cnt = 0;

    function automatic logic [11:0] obs_vec();
        return {BTN_SET, BTN_INC, BTN_DEC, prev_SET, setFlag,
                targetFlag_H, targetFlag_M, targetFlag_S, field, commit, abort};
    endfunction

    function automatic logic [11:0] exp_vec();
        return {e_bset, e_binc, e_bdec, e_prev, (e_field != 2'd0),
                (e_field == 2'd1), (e_field == 2'd2), (e_field == 2'd3),
                e_field, e_commit, e_abort};
    endfunction

    task automatic push(input int c);
        ev_t e;
        e.c = c;
        e.v = exp_vec();
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Raw SET high for 'hold' cycles, then released; returns at the release cycle.
    task automatic press_set(input int hold);
        int k;
        k = cyc;
        set_raw = 1'b1;
        e_bset = 1'b1;
        push(k + 6);
        e_prev = 1'b1;
        if (e_field == 2'd3) begin
            e_field  = 2'd0;
            e_commit = 1'b1;
        end else begin
            e_field = e_field + 2'd1;
        end
        push(k + 7);
        if (e_commit) begin
            e_commit = 1'b0;
            push(k + 8);
        end
        tick(hold);
        k = cyc;
        set_raw = 1'b0;
        e_bset = 1'b0;
        push(k + 6);
        e_prev = 1'b0;
        push(k + 7);
    endtask

    always @(negedge CLK) begin : monitor
        logic [11:0] o;
        ev_t         e;
        if (rise_win && dut.set_rise) rise_cnt++;
        if (mon_en) begin
            o = obs_vec();
            if (o !== last_obs) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cyc=%0d got=%b want=no change (was %b)", cyc, o, last_obs);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.c != cyc) || (e.v !== o)) begin
                        n_fail++;
                        $display("FAIL output_event got cyc=%0d vec=%b want cyc=%0d vec=%b", cyc, o, e.c, e.v);
                    end
                end
                last_obs = o;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin : stim
`ifdef AL_TIMEOUT_EN
        int d;
`endif
        tick(3);
        n_cmp++;
        if (obs_vec() !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%b want=%b", obs_vec(), 12'd0);
        end
        RST_N = 1'b1;
        mon_en = 1'b1;

        // Simultaneous INC and DEC both forwarded, 6 edges after the raw change.
        inc_raw = 1'b1;
        dec_raw = 1'b1;
        e_binc = 1'b1;
        e_bdec = 1'b1;
        push(cyc + 6);
        tick(6);
        inc_raw = 1'b0;
        dec_raw = 1'b0;
        e_binc = 1'b0;
        e_bdec = 1'b0;
        push(cyc + 6);
        tick(10);

        // Three 3-cycle INC glitches: nothing may change.
        for (int g = 0; g < 3; g++) begin
            inc_raw = 1'b1;
            tick(3);
            inc_raw = 1'b0;
            tick(1);
        end
        tick(10);

        // Four clean presses: H, M, S, IDLE with commit.
        for (int p = 0; p < 4; p++) begin
            press_set(10);
            tick(10);
        end

        // Long hold gives exactly one transition.
        rise_win = 1'b1;
        press_set(100);
        tick(10);
        rise_win = 1'b0;
        n_cmp++;
        if (rise_cnt != 1) begin
            n_fail++;
            $display("FAIL set_rise_count got=%0d want=1", rise_cnt);
        end

        press_set(10);
`ifdef AL_TIMEOUT_EN
        // In SET_M: INC activity near the end restarts the idle count.
        d = cyc + 6;
        tick(14);
        inc_raw = 1'b1;
        e_binc = 1'b1;
        push(d + 14);
        tick(5);
        inc_raw = 1'b0;
        e_binc = 1'b0;
        push(d + 19);
        e_field = 2'd0;
        e_abort = 1'b1;
        push(d + 39);
        e_abort = 1'b0;
        push(d + 40);
        tick(40);

        // Undisturbed timeout from SET_H: exactly 20 idle cycles.
        press_set(10);
        d = cyc + 6;
        e_field = 2'd0;
        e_abort = 1'b1;
        push(d + 20);
        e_abort = 1'b0;
        push(d + 21);
        tick(30);
        for (int p = 0; p < 3; p++) begin
            press_set(10);
            tick(10);
        end
`else
        tick(40);
        press_set(10);
        tick(10);
`endif

        // Reset in SET_S with INC held: session discarded, INC needs 6 cycles again.
        inc_raw = 1'b1;
        e_binc = 1'b1;
        push(cyc + 6);
        tick(8);
        RST_N = 1'b0;
        e_binc = 1'b0;
        e_field = 2'd0;
        push(cyc + 1);
        tick(1);
        RST_N = 1'b1;
        e_binc = 1'b1;
        push(cyc + 6);
        tick(10);
        inc_raw = 1'b0;
        e_binc = 1'b0;
        push(cyc + 6);
        tick(12);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events got=%0d want=0 (next cyc=%0d vec=%b)",
                     exp_q.size(), exp_q[0].c, exp_q[0].v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
